// File: rtl/logic_gate_pkg.sv
// rtl/logic_gate_pkg.sv - op encoding and per-bit evaluator for the logic gate unit
package logic_gate_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } lgu_op_e;

  // Single-bit evaluation; the top replicates it across WIDTH so the package stays width-agnostic.
  function automatic logic lgu_eval(input lgu_op_e op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_PASS_A: r = a;
      OP_NOT_A:  r = ~a;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_gate_unit_if.sv
// rtl/logic_gate_unit_if.sv - operand/result handshake bundle for the logic gate unit
interface logic_gate_unit_if import logic_gate_pkg::*; #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_ones;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, y_zero, y_ones
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, y_zero, y_ones
  );

endinterface

// File: rtl/lgu_skid_buf.sv
// rtl/lgu_skid_buf.sv - two-entry output/skid register pair with valid/ready handshake
module lgu_skid_buf #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          out_v, out_v_n;
  logic [DW-1:0] out_d, out_d_n;
  logic          skd_v, skd_v_n;
  logic [DW-1:0] skd_d, skd_d_n;
  logic          rdy;
  logic          accept;
  logic          deliver;

  assign accept  = in_valid & rdy;
  assign deliver = out_v & out_ready;

  always_comb begin
    out_v_n = out_v;
    out_d_n = out_d;
    skd_v_n = skd_v;
    skd_d_n = skd_d;
    if (deliver) begin
      if (skd_v) begin
        // Older skid entry moves forward; any new word takes its place behind it.
        out_d_n = skd_d;
        skd_v_n = accept;
        if (accept) skd_d_n = in_data;
      end else begin
        out_v_n = accept;
        if (accept) out_d_n = in_data;
      end
    end else if (!out_v) begin
      out_v_n = accept;
      if (accept) out_d_n = in_data;
    end else if (accept) begin
      skd_v_n = 1'b1;
      skd_d_n = in_data;
    end
  end

  // rdy is held low through reset and rises one edge later, so no accept can race the release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v <= 1'b0;
      out_d <= '0;
      skd_v <= 1'b0;
      skd_d <= '0;
      rdy   <= 1'b0;
    end else begin
      out_v <= out_v_n;
      out_d <= out_d_n;
      skd_v <= skd_v_n;
      skd_d <= skd_d_n;
      rdy   <= ~skd_v_n;
    end
  end

  assign in_ready  = rdy;
  assign out_valid = out_v;
  assign out_data  = out_d;

endmodule

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered WIDTH-bit two-operand logic unit with buffered handshake
module logic_gate_unit import logic_gate_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_gate_unit_if.slave   bus
);

  logic [WIDTH-1:0] res;
  logic [WIDTH+1:0] in_data;
  logic [WIDTH+1:0] out_data;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign res[i] = lgu_eval(lgu_op_e'(bus.op), bus.a[i], bus.b[i]);
  end

  // Flags are computed here so they are stored with the result and stay consistent with y.
  assign in_data = {res, ~|res, &res};

  lgu_skid_buf #(
    .DW (WIDTH + 2)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data)
  );

  assign bus.y      = out_data[WIDTH+1:2];
  assign bus.y_zero = out_data[1];
  assign bus.y_ones = out_data[0];

endmodule

// File: tb/tb_logic_gate_unit.sv
// tb/tb_logic_gate_unit.sv - directed self-checking bench for logic_gate_unit
module tb_logic_gate_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic_gate_unit_if #(.WIDTH(1)) if1 ();
  logic_gate_unit_if #(.WIDTH(8)) if8 ();

  logic_gate_unit #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  logic_gate_unit #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = a;
      default: r = ~a;
    endcase
    return {r, (r == 8'h00), (r == 8'hFF)};
  endfunction

  logic [9:0] q[$];
  logic [9:0] got;
  logic [2:0] t_op [10];
  logic [7:0] t_a  [10];
  logic [7:0] t_b  [10];
  logic [9:0] t_exp[10];
  logic       p_a  [4];
  logic       p_b  [4];
  logic       p_y  [4];
  int         n_acc;
  int         n_dlv;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    if1.in_valid = 0; if1.op = 0; if1.a = 0; if1.b = 0; if1.out_ready = 1;
    if8.in_valid = 0; if8.op = 0; if8.a = 0; if8.b = 0; if8.out_ready = 1;

    // Reset state
    #3;
    chk("rst_in_ready", if8.in_ready, 0);
    chk("rst_out_valid", if8.out_valid, 0);
    chk("rst_y", {if8.y, if8.y_zero, if8.y_ones}, 0);
    chk("rst_in_ready_w1", if1.in_ready, 0);
    #9 rst_n = 1'b1;
    step();
    chk("rel_in_ready", if8.in_ready, 1);
    chk("rel_in_ready_w1", if1.in_ready, 1);

    // WIDTH=1 AND truth table
    p_a = '{0, 1, 0, 1}; p_b = '{0, 0, 1, 1}; p_y = '{0, 0, 0, 1};
    if1.op = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if1.a = p_a[i]; if1.b = p_b[i]; if1.in_valid = 1;
      step();
      chk("w1_valid", if1.out_valid, 1);
      chk("w1_y", if1.y, p_y[i]);
      chk("w1_flags", {if1.y_zero, if1.y_ones}, p_y[i] ? 2'b01 : 2'b10);
    end
    if1.in_valid = 0;
    step();
    chk("w1_drain", if1.out_valid, 0);

    // WIDTH=8 all ops on F0/3C plus all-ones cases
    t_op = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 2};
    t_a  = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hFF, 8'hFF};
    t_b  = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hFF, 8'hFF};
    t_exp = '{{8'h30, 2'b00}, {8'hFC, 2'b00}, {8'hCC, 2'b00}, {8'hCF, 2'b00}, {8'h03, 2'b00},
              {8'h33, 2'b00}, {8'hF0, 2'b00}, {8'h0F, 2'b00}, {8'hFF, 2'b01}, {8'h00, 2'b10}};
    for (int i = 0; i < 10; i++) begin
      if8.op = t_op[i]; if8.a = t_a[i]; if8.b = t_b[i]; if8.in_valid = 1;
      step();
      chk("w8_valid", if8.out_valid, 1);
      chk($sformatf("w8_op%0d", i), {if8.y, if8.y_zero, if8.y_ones}, t_exp[i]);
    end
    if8.in_valid = 0;
    step();
    chk("w8_drain", if8.out_valid, 0);

    // Back-pressure: two accepted, third held until drain
    if8.out_ready = 0;
    if8.op = 0; if8.a = 8'hF0; if8.b = 8'h3C; if8.in_valid = 1;
    step();
    chk("bp_first_y", if8.y, 8'h30);
    chk("bp_ready1", if8.in_ready, 1);
    if8.op = 1;
    step();
    chk("bp_ready2", if8.in_ready, 0);
    chk("bp_hold_y", if8.y, 8'h30);
    if8.op = 2;
    step();
    chk("bp_ready3", if8.in_ready, 0);
    chk("bp_valid_held", if8.out_valid, 1);
    step();
    chk("bp_stable_y", if8.y, 8'h30);
    if8.out_ready = 1;
    step();
    chk("bp_second_y", if8.y, 8'hFC);
    chk("bp_ready_back", if8.in_ready, 1);
    step();
    chk("bp_third_y", if8.y, 8'hCC);
    if8.in_valid = 0;
    step();
    chk("bp_drain", if8.out_valid, 0);

    // Streaming 16 random vectors with out_ready=1
    for (int i = 0; i < 16; i++) begin
      if8.op = 3'($urandom_range(0, 7)); if8.a = 8'($urandom); if8.b = 8'($urandom);
      if8.in_valid = 1;
      got = model(if8.op, if8.a, if8.b);
      step();
      chk("st_no_bubble", if8.out_valid, 1);
      chk("st_data", {if8.y, if8.y_zero, if8.y_ones}, got);
    end
    if8.in_valid = 0;
    step();

    // Toggling out_ready with continuous input
    n_acc = 0; n_dlv = 0; q = {};
    for (int i = 0; i < 24; i++) begin
      if8.out_ready = i[0];
      if8.op = 3'($urandom_range(0, 7)); if8.a = 8'($urandom); if8.b = 8'($urandom);
      if8.in_valid = 1;
      if (if8.in_ready) begin q.push_back(model(if8.op, if8.a, if8.b)); n_acc++; end
      if (if8.out_valid && if8.out_ready) begin
        chk("tg_order", {if8.y, if8.y_zero, if8.y_ones}, (q.size() > 0) ? q[0] : 10'h3FF);
        if (q.size() > 0) void'(q.pop_front());
        n_dlv++;
      end
      step();
    end
    if8.in_valid = 0; if8.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (if8.out_valid) begin
        chk("tg_drain_order", {if8.y, if8.y_zero, if8.y_ones}, (q.size() > 0) ? q[0] : 10'h3FF);
        if (q.size() > 0) void'(q.pop_front());
        n_dlv++;
      end
      step();
    end
    chk("tg_count", n_dlv, n_acc);
    chk("tg_empty", q.size(), 0);

    // Asynchronous reset with OUT and SKD both full
    if8.out_ready = 0;
    if8.op = 6; if8.a = 8'hFF; if8.b = 8'h00; if8.in_valid = 1;
    step();
    if8.op = 0; if8.a = 8'hF0; if8.b = 8'h3C;
    step();
    if8.in_valid = 0;
    chk("rm_full_valid", if8.out_valid, 1);
    chk("rm_full_y", {if8.y, if8.y_zero, if8.y_ones}, {8'hFF, 2'b01});
    chk("rm_full_ready", if8.in_ready, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("rm_valid0", if8.out_valid, 0);
    chk("rm_y0", {if8.y, if8.y_zero, if8.y_ones}, 0);
    chk("rm_ready0", if8.in_ready, 0);
    #2 rst_n = 1'b1;
    step();
    chk("rm_ready_rel", if8.in_ready, 1);
    chk("rm_no_stale", if8.out_valid, 0);
    if8.out_ready = 1;
    step();
    chk("rm_no_stale2", if8.out_valid, 0);
    if8.op = 1; if8.a = 8'h0F; if8.b = 8'hF0; if8.in_valid = 1;
    step();
    chk("rm_fresh_valid", if8.out_valid, 1);
    chk("rm_fresh_y", {if8.y, if8.y_zero, if8.y_ones}, {8'hFF, 2'b01});
    if8.in_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
